// File: rtl/divremsqrt_fdivsqrt_fsm_pkg.sv
// Shared types and constants for the divide/remainder/sqrt sequencing FSM.
package divremsqrt_fdivsqrt_fsm_pkg;

  // Default width of the iteration counter and the CyclesE input.
  localparam int unsigned CntwDefault = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fdivsqrt_state_t;

endpackage

// File: rtl/divremsqrt_fdivsqrt_fsm_if.sv
// Execute-stage handshake between the pipeline and the div/sqrt sequencer.
interface divremsqrt_fdivsqrt_fsm_if
  import divremsqrt_fdivsqrt_fsm_pkg::*;
#(
  parameter int unsigned CNTW = CntwDefault
);
  logic            FDivStartE;
  logic            IDivStartE;
  logic            SpecialCaseE;
  logic [CNTW-1:0] CyclesE;
  logic            WZeroE;
  logic            StallM;
  logic            FlushE;
  logic            IFDivStartE;
  logic            FDivBusyE;
  logic            FDivDoneE;
  logic [CNTW-1:0] StepE;

  modport master (
    output FDivStartE, IDivStartE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
    input  IFDivStartE, FDivBusyE, FDivDoneE, StepE
  );

  modport slave (
    input  FDivStartE, IDivStartE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
    output IFDivStartE, FDivBusyE, FDivDoneE, StepE
  );
endinterface

// File: rtl/divremsqrt_step_counter.sv
// Loadable iteration down-counter; never decrements below one.
module divremsqrt_step_counter #(
  parameter int unsigned Width = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] step_o,
  output logic             one_o
);
  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] step_q, step_d;

  // Next count: clear beats load beats decrement.
  always_comb begin
    step_d = step_q;
    if (clr_i) begin
      step_d = '0;
    end else if (load_i) begin
      step_d = load_val_i;
    end else if (dec_i && (step_q > One)) begin
      step_d = step_q - One;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;
  assign one_o  = (step_q == One);
endmodule

// File: rtl/divremsqrt_fdivsqrt_fsm.sv
// Sequencer for the shared div/rem/sqrt iteration datapath.
// Define FDIVSQRT_EARLYTERM_EN to let a zero residual (WZeroE) end iteration early.
module divremsqrt_fdivsqrt_fsm
  import divremsqrt_fdivsqrt_fsm_pkg::*;
#(
  parameter int unsigned CNTW        = CntwDefault,
  parameter bit          IDIV_ON_FPU = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  divremsqrt_fdivsqrt_fsm_if.slave   bus
);
  fdivsqrt_state_t state_q;

  logic start_req, start, step_one, et_hit;
  logic cnt_clr, cnt_load, cnt_dec;

`ifdef FDIVSQRT_EARLYTERM_EN
  assign et_hit = bus.WZeroE;
`else
  assign et_hit = 1'b0;
`endif

  assign start_req = bus.FDivStartE | (bus.IDivStartE & IDIV_ON_FPU);
  assign start     = start_req & (state_q == IDLE) & ~bus.StallM & ~bus.FlushE;

  // Counter control follows the FSM; StepE is zero whenever the FSM is not in BUSY.
  always_comb begin
    cnt_clr  = bus.FlushE
             | (start & bus.SpecialCaseE)
             | ((state_q == BUSY) & (step_one | et_hit));
    cnt_load = start & ~bus.SpecialCaseE;
    cnt_dec  = (state_q == BUSY) & ~step_one & ~et_hit;
  end

  divremsqrt_step_counter #(
    .Width (CNTW)
  ) u_step_counter (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (bus.CyclesE),
    .dec_i      (cnt_dec),
    .step_o     (bus.StepE),
    .one_o      (step_one)
  );

  // State register; flush overrides every transition including a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (bus.FlushE) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_q <= bus.SpecialCaseE ? DONE : BUSY;
        BUSY: if (step_one || et_hit) state_q <= DONE;
        DONE: if (!bus.StallM) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.IFDivStartE = start;
  assign bus.FDivBusyE   = (state_q == BUSY) | (start & ~bus.SpecialCaseE);
  assign bus.FDivDoneE   = (state_q == DONE);

  // A zero iteration count would leave BUSY with no terminating condition.
  a_cycles_nonzero : assert property (@(posedge clk) disable iff (reset)
    cnt_load |-> (bus.CyclesE != '0));
endmodule

// File: doc/divremsqrt_fdivsqrt_fsm.md
Name: divremsqrt_fdivsqrt_fsm

Overview:
Sequencing controller for the shared divide/remainder/square-root iteration datapath in the FPU.
- Accepts FP divide/sqrt and integer divide/remainder starts from the Execute stage.
- Counts digit-recurrence iterations and terminates early on an exact result (zero residual).
- Asserts busy to stall the pipeline and signals done so Memory-stage postprocessing captures the result.
- Handles special-case bypass, flush and Memory-stage stall.

Parameters:
- CNTW, 7, width of the iteration counter and cycle-count input.
- IDIV_ON_FPU, 1, when 1 integer divides use this datapath; when 0 IDivStartE is ignored.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- FDivStartE  in  1  FP divide/sqrt issued in Execute
- IDivStartE  in  1  integer div/rem issued in Execute
- SpecialCaseE  in  1  NaN/Inf/zero/div-by-zero case; no iterations needed
- CyclesE  in  CNTW  number of iterations for this operation, precomputed by preprocessing; legal range 1..2^CNTW-1
- WZeroE  in  1  residual is zero (exact result), from the early-termination check
- StallM  in  1  Memory stage stalled
- FlushE  in  1  Execute flush
- IFDivStartE  out  1  one-cycle start pulse that loads the datapath registers
- FDivBusyE  out  1  operation in progress; stalls the pipeline
- FDivDoneE  out  1  result ready for the Memory stage
- StepE  out  CNTW  remaining iterations (debug/verification visibility)

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async, active-high) puts the FSM in IDLE with StepE=0; all outputs are 0 in reset.
- StartReq = FDivStartE | (IDivStartE & IDIV_ON_FPU).
- IFDivStartE = StartReq & (state==IDLE) & ~StallM & ~FlushE. This is combinational and lasts one cycle.
- Transitions from IDLE:
  - On IFDivStartE with SpecialCaseE=1: go to DONE, StepE=0.
  - On IFDivStartE with SpecialCaseE=0: go to BUSY, load StepE=CyclesE.
  - Otherwise stay in IDLE.
- Transitions from BUSY, evaluated each cycle in this priority:
  - StepE==1: go to DONE, StepE=0.
  - WZeroE=1: go to DONE, StepE=0 (early termination; see Optional Feature).
  - Otherwise StepE decrements by 1 and the FSM stays in BUSY.
- Transitions from DONE:
  - StallM=1: hold DONE.
  - StallM=0: go to IDLE next cycle.
- FlushE=1 in any state forces IDLE next cycle and clears StepE. Flush takes priority over every other transition and over start.
- FDivBusyE = (state==BUSY) | (IFDivStartE & ~SpecialCaseE). Busy is therefore asserted in the start cycle itself.
- FDivDoneE = (state==DONE).
- Latency, non-special operation: start cycle S, first BUSY cycle S+1, DONE at S+CyclesE+1.
- Latency, special case: DONE at S+1.
- A StartReq arriving while BUSY or DONE is not accepted. No IFDivStartE is issued; the upstream pipeline holds the request via FDivBusyE.
- CyclesE=1 completes after exactly one BUSY cycle. CyclesE=0 is illegal, and an assertion flags it in simulation.
- StepE never wraps: it is loaded only in IDLE and decrements only while StepE>1.
- Reset asserted mid-operation returns the FSM to IDLE immediately, independent of clk.

Optional Feature:
- FDIVSQRT_EARLYTERM_EN defined: WZeroE in BUSY terminates early as described above.
- Macro undefined: WZeroE is ignored and every non-special operation runs the full CyclesE iterations.

Decomposition:
- Shared package holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} fdivsqrt_state_t
  - CNTW default constant
- Natural sub-module: divremsqrt_step_counter, a loadable down-counter with load, decrement and clear inputs and a one-flag output (StepE==1).

Test Plan:
- FDivStartE=1, SpecialCaseE=0, CyclesE=5, no WZeroE -> IFDivStartE pulse at cycle 0; FDivBusyE high cycles 0-5; FDivDoneE at cycle 6; IDLE at cycle 7.
- Same as above with WZeroE=1 at BUSY cycle 2 and macro defined -> DONE at cycle 3. Macro undefined -> DONE at cycle 6.
- SpecialCaseE=1 with start -> FDivBusyE=0; DONE at cycle 1; StepE remains 0.
- DONE with StallM held high 3 cycles -> FDivDoneE stays high 3 cycles; IDLE one cycle after StallM falls; new StartReq held meanwhile -> IFDivStartE only in IDLE.
- FlushE during BUSY at StepE=3 -> IDLE next cycle, StepE=0, no FDivDoneE. Async reset mid-BUSY -> immediate IDLE with outputs 0.
- IDivStartE=1 with IDIV_ON_FPU=0 -> no start pulse, stays IDLE. With IDIV_ON_FPU=1 and CyclesE=1 -> DONE at cycle 2.
